pcie_link_tx_scheduler: RTL and testbench

PCIE_LINK_TX_SCHEDULER -- requirements
Module: pcie_link_tx_scheduler

---
 rtl/pcie_link_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_pcie_link_tx_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_link_tx_scheduler.sv
// Link-layer transmit arbiter: merges the TLP and DLLP AXI-Stream inputs onto
// the single PHY stream. Grants are packet-atomic, DLLPs win when urgent or
// when TLPs have starved them for MAX_TLP_BURST packets, and a falling link
// only stops new grants after the current packet.
module pcie_link_tx_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 3,
  parameter int MAX_TLP_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep,
  input  logic                  s_axis_tlp_tvalid,
  input  logic                  s_axis_tlp_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser,
  output logic                  s_axis_tlp_tready,

  input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep,
  input  logic                  s_axis_dllp_tvalid,
  input  logic                  s_axis_dllp_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_dllp_tuser,
  output logic                  s_axis_dllp_tready,

  output logic [DATA_WIDTH-1:0] m_axis_phy_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_phy_tkeep,
  output logic                  m_axis_phy_tvalid,
  output logic                  m_axis_phy_tlast,
  output logic [USER_WIDTH-1:0] m_axis_phy_tuser,
  input  logic                  m_axis_phy_tready,

  input  logic                  phy_link_up_i,
  input  logic                  dllp_urgent_i,
  output logic [1:0]            grant_o,
  output logic [15:0]           tlp_count_o,
  output logic [15:0]           dllp_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TLP  = 2'b01,
    DLLP = 2'b10
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_TLP_BURST);

  state_t     state;
  logic [7:0] starve_cnt;
  logic       tlp_done;
  logic       dllp_done;
  logic       pick_dllp;

  // Zero-latency mux of the granted input onto the PHY stream
  always_comb begin
    m_axis_phy_tdata   = '0;
    m_axis_phy_tkeep   = '0;
    m_axis_phy_tvalid  = 1'b0;
    m_axis_phy_tlast   = 1'b0;
    m_axis_phy_tuser   = '0;
    s_axis_tlp_tready  = 1'b0;
    s_axis_dllp_tready = 1'b0;
    case (state)
      TLP: begin
        m_axis_phy_tdata  = s_axis_tlp_tdata;
        m_axis_phy_tkeep  = s_axis_tlp_tkeep;
        m_axis_phy_tvalid = s_axis_tlp_tvalid;
        m_axis_phy_tlast  = s_axis_tlp_tlast;
        m_axis_phy_tuser  = s_axis_tlp_tuser;
        s_axis_tlp_tready = m_axis_phy_tready;
      end
      DLLP: begin
        m_axis_phy_tdata   = s_axis_dllp_tdata;
        m_axis_phy_tkeep   = s_axis_dllp_tkeep;
        m_axis_phy_tvalid  = s_axis_dllp_tvalid;
        m_axis_phy_tlast   = s_axis_dllp_tlast;
        m_axis_phy_tuser   = s_axis_dllp_tuser;
        s_axis_dllp_tready = m_axis_phy_tready;
      end
      default: ;
    endcase
  end

  // End-of-packet detection and the DLLP-priority decision used in IDLE
  always_comb begin
    tlp_done  = (state == TLP) && s_axis_tlp_tvalid && m_axis_phy_tready && s_axis_tlp_tlast;
    dllp_done = (state == DLLP) && s_axis_dllp_tvalid && m_axis_phy_tready && s_axis_dllp_tlast;
    pick_dllp = s_axis_dllp_tvalid &&
                (dllp_urgent_i || (starve_cnt >= BURST_LIMIT) || !s_axis_tlp_tvalid);
  end

  // Arbitration FSM; grant is registered alongside the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (phy_link_up_i) begin
            if (pick_dllp) begin
              state   <= DLLP;
              grant_o <= 2'b10;
            end else if (s_axis_tlp_tvalid) begin
              state   <= TLP;
              grant_o <= 2'b01;
            end
          end
        end
        TLP: begin
          if (tlp_done) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        DLLP: begin
          if (dllp_done) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Count TLPs sent while a DLLP is kept waiting; a sent DLLP clears it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (dllp_done) begin
      starve_cnt <= '0;
    end else if (tlp_done && s_axis_dllp_tvalid && (starve_cnt != 8'hFF)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Completed-packet counters, free-running wrap at 16 bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tlp_count_o  <= '0;
      dllp_count_o <= '0;
    end else begin
      tlp_count_o  <= tlp_count_o + {15'd0, tlp_done};
      dllp_count_o <= dllp_count_o + {15'd0, dllp_done};
    end
  end

endmodule

// File: tb/tb_pcie_link_tx_scheduler.sv
// Directed bench for pcie_link_tx_scheduler: a table of single-packet IDLE
// decisions followed by hand-written multi-cycle sequences.
module tb_pcie_link_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [31:0] tlp_tdata,  dllp_tdata,  phy_tdata;
  logic [3:0]  tlp_tkeep,  dllp_tkeep,  phy_tkeep;
  logic        tlp_tvalid, dllp_tvalid, phy_tvalid;
  logic        tlp_tlast,  dllp_tlast,  phy_tlast;
  logic [2:0]  tlp_tuser,  dllp_tuser,  phy_tuser;
  logic        tlp_tready, dllp_tready, phy_tready;
  logic        link_up, urgent;
  logic [1:0]  grant;
  logic [15:0] tlp_count, dllp_count;

  int tests = 0;
  int fails = 0;

  // PHY ready source: 0 = always ready, 1 = toggling, 2 = manual (rdy)
  int   rdy_mode = 0;
  logic rdy = 1'b0;
  logic tog = 1'b0;
  assign phy_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : rdy;

  pcie_link_tx_scheduler #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3), .MAX_TLP_BURST(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tlp_tdata(tlp_tdata), .s_axis_tlp_tkeep(tlp_tkeep),
    .s_axis_tlp_tvalid(tlp_tvalid), .s_axis_tlp_tlast(tlp_tlast),
    .s_axis_tlp_tuser(tlp_tuser), .s_axis_tlp_tready(tlp_tready),
    .s_axis_dllp_tdata(dllp_tdata), .s_axis_dllp_tkeep(dllp_tkeep),
    .s_axis_dllp_tvalid(dllp_tvalid), .s_axis_dllp_tlast(dllp_tlast),
    .s_axis_dllp_tuser(dllp_tuser), .s_axis_dllp_tready(dllp_tready),
    .m_axis_phy_tdata(phy_tdata), .m_axis_phy_tkeep(phy_tkeep),
    .m_axis_phy_tvalid(phy_tvalid), .m_axis_phy_tlast(phy_tlast),
    .m_axis_phy_tuser(phy_tuser), .m_axis_phy_tready(phy_tready),
    .phy_link_up_i(link_up), .dllp_urgent_i(urgent), .grant_o(grant),
    .tlp_count_o(tlp_count), .dllp_count_o(dllp_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      tog = ~tog;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // PHY-side monitor: records every accepted beat {data,keep,user,last,grant}
  logic [41:0] cap [0:255];
  int          cap_cyc [0:255];
  int          mon_cnt = 0;
  int          cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (phy_tvalid && phy_tready && mon_cnt < 256) begin
      cap[mon_cnt]     <= {phy_tdata, phy_tkeep, phy_tuser, phy_tlast, grant};
      cap_cyc[mon_cnt] <= cyc;
      mon_cnt          <= mon_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tdat(input logic [7:0] tag, input logic [7:0] pkt, input int beat);
    return {tag, pkt, 8'h00, 8'(beat)};
  endfunction

  // TLP beats tagged A0 carry keep F / user 101; DLLP beats tagged D0 carry keep 3 / user 010
  function automatic logic [41:0] exp_beat(input logic [7:0] tag, input logic [7:0] pkt,
                                           input int beat, input logic last);
    if (tag == 8'hA0) return {tdat(tag, pkt, beat), 4'hF, 3'b101, last, 2'b01};
    return {tdat(tag, pkt, beat), 4'h3, 3'b010, last, 2'b10};
  endfunction

  task automatic expect_pkt(input string name, input int idx, input logic [7:0] tag,
                            input logic [7:0] pkt, input int len);
    for (int b = 0; b < len; b++)
      check($sformatf("%s_beat%0d", name, b), 64'(cap[idx + b]), 64'(exp_beat(tag, pkt, b, b == len - 1)));
  endtask

  task automatic drive_tlp(input int npkt, input int len, input logic [7:0] pid);
    bit ok;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < len; b++) begin
        @(negedge clk);
        tlp_tvalid = 1'b1;
        tlp_tdata  = tdat(8'hA0, pid + 8'(p), b);
        tlp_tkeep  = 4'hF;
        tlp_tuser  = 3'b101;
        tlp_tlast  = (b == len - 1);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
          @(posedge clk);
          if (tlp_tready) ok = 1'b1;
        end
        if (!ok) begin
          check("tlp_handshake_timeout", 64'd0, 64'd1);
          tlp_tvalid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    tlp_tvalid = 1'b0;
    tlp_tlast  = 1'b0;
  endtask

  task automatic drive_dllp(input int npkt, input int len, input logic [7:0] pid);
    bit ok;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < len; b++) begin
        @(negedge clk);
        dllp_tvalid = 1'b1;
        dllp_tdata  = tdat(8'hD0, pid + 8'(p), b);
        dllp_tkeep  = 4'h3;
        dllp_tuser  = 3'b010;
        dllp_tlast  = (b == len - 1);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
          @(posedge clk);
          if (dllp_tready) ok = 1'b1;
        end
        if (!ok) begin
          check("dllp_handshake_timeout", 64'd0, 64'd1);
          dllp_tvalid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    dllp_tvalid = 1'b0;
    dllp_tlast  = 1'b0;
  endtask

  typedef struct {
    logic       link;
    logic       tv;
    logic       dv;
    logic       urg;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs [7];
  int   exp_tlp = 0;
  int   exp_dllp = 0;
  int   start;
  int   nonidle;

  initial begin
    // link, tlp valid, dllp valid, urgent -> grant after one IDLE decision
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00};  // link down: no grant
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01};  // TLP only
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10};  // DLLP only
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};  // both, not urgent, no starvation
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10};  // both, urgent
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};  // nothing valid
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};  // urgent without a DLLP

    rst = 1'b1; link_up = 1'b0; urgent = 1'b0;
    tlp_tdata = '0; tlp_tkeep = '0; tlp_tvalid = 1'b0; tlp_tlast = 1'b0; tlp_tuser = '0;
    dllp_tdata = '0; dllp_tkeep = '0; dllp_tvalid = 1'b0; dllp_tlast = 1'b0; dllp_tuser = '0;
    rdy_mode = 2; rdy = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({grant, phy_tvalid, tlp_tready, dllp_tready}), 64'd0);
    check("reset_counts", 64'({tlp_count, dllp_count}), 64'd0);
    rst = 1'b0;

    // ---- table of IDLE decisions ----
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      link_up = vecs[i].link; urgent = vecs[i].urg; rdy = 1'b0;
      tlp_tvalid  = vecs[i].tv; tlp_tdata  = 32'h1111_0000 + 32'(i);
      tlp_tkeep   = 4'hF; tlp_tuser = 3'b101; tlp_tlast = 1'b1;
      dllp_tvalid = vecs[i].dv; dllp_tdata = 32'h2222_0000 + 32'(i);
      dllp_tkeep  = 4'h3; dllp_tuser = 3'b010; dllp_tlast = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].exp_grant));
      if (vecs[i].exp_grant != 2'b00) begin
        rdy = 1'b1;
        #1;
        if (vecs[i].exp_grant == 2'b01)
          check($sformatf("vec%0d_mux", i), 64'({phy_tvalid, phy_tdata, phy_tkeep, phy_tuser, phy_tlast}),
                64'({1'b1, 32'h1111_0000 + 32'(i), 4'hF, 3'b101, 1'b1}));
        else
          check($sformatf("vec%0d_mux", i), 64'({phy_tvalid, phy_tdata, phy_tkeep, phy_tuser, phy_tlast}),
                64'({1'b1, 32'h2222_0000 + 32'(i), 4'h3, 3'b010, 1'b1}));
        check($sformatf("vec%0d_treadys", i), 64'({tlp_tready, dllp_tready}),
              (vecs[i].exp_grant == 2'b01) ? 64'b10 : 64'b01);
        @(negedge clk);
        if (vecs[i].exp_grant == 2'b01) exp_tlp++; else exp_dllp++;
        check($sformatf("vec%0d_back_idle", i), 64'(grant), 64'd0);
      end else begin
        check($sformatf("vec%0d_idle_outputs", i), 64'({phy_tvalid, tlp_tready, dllp_tready}), 64'd0);
      end
      tlp_tvalid = 1'b0; dllp_tvalid = 1'b0; rdy = 1'b0;
    end
    check("table_tlp_count", 64'(tlp_count), 64'(exp_tlp));
    check("table_dllp_count", 64'(dllp_count), 64'(exp_dllp));
    check("table_starve_clear", 64'(dut.starve_cnt), 64'd0);

    link_up = 1'b1; urgent = 1'b0; rdy_mode = 0;

    // ---- 3-beat TLP alone ----
    start = mon_cnt;
    drive_tlp(1, 3, 8'h10);
    exp_tlp++;
    check("single_tlp_grant_idle", 64'(grant), 64'd0);
    check("single_tlp_beats", 64'(mon_cnt - start), 64'd3);
    expect_pkt("single_tlp", start, 8'hA0, 8'h10, 3);
    check("single_tlp_count", 64'(tlp_count), 64'(exp_tlp));

    // ---- urgent DLLP beats a waiting TLP ----
    urgent = 1'b1;
    start = mon_cnt;
    fork
      drive_tlp(1, 2, 8'h20);
      drive_dllp(1, 1, 8'h21);
    join
    urgent = 1'b0;
    exp_tlp++; exp_dllp++;
    check("urgent_beats", 64'(mon_cnt - start), 64'd3);
    expect_pkt("urgent_dllp_first", start, 8'hD0, 8'h21, 1);
    expect_pkt("urgent_tlp_second", start + 1, 8'hA0, 8'h20, 2);
    check("urgent_dllp_count", 64'(dllp_count), 64'(exp_dllp));

    // ---- starvation limit: 4 TLPs then the pending DLLP ----
    start = mon_cnt;
    fork
      drive_tlp(6, 2, 8'h30);
      drive_dllp(1, 1, 8'h40);
    join
    exp_tlp += 6; exp_dllp++;
    check("starve_beats", 64'(mon_cnt - start), 64'd13);
    for (int p = 0; p < 4; p++)
      expect_pkt($sformatf("starve_tlp%0d", p), start + 2 * p, 8'hA0, 8'h30 + 8'(p), 2);
    expect_pkt("starve_dllp", start + 8, 8'hD0, 8'h40, 1);
    expect_pkt("starve_tlp4", start + 9, 8'hA0, 8'h34, 2);
    expect_pkt("starve_tlp5", start + 11, 8'hA0, 8'h35, 2);
    check("starve_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
    check("idle_gap_between_pkts", 64'(cap_cyc[start + 2] - cap_cyc[start + 1]), 64'd2);
    check("starve_counts", 64'({tlp_count, dllp_count}), 64'({16'(exp_tlp), 16'(exp_dllp)}));

    // ---- urgent raised mid 5-beat TLP with toggling ready ----
    rdy_mode = 1;
    start = mon_cnt;
    fork
      drive_tlp(1, 5, 8'h50);
      begin
        for (int t = 0; t < 200 && mon_cnt < start + 1; t++) @(negedge clk);
        urgent = 1'b1;
        drive_dllp(1, 1, 8'h51);
      end
    join
    urgent = 1'b0; rdy_mode = 0;
    exp_tlp++; exp_dllp++;
    check("midurgent_beats", 64'(mon_cnt - start), 64'd6);
    expect_pkt("midurgent_tlp", start, 8'hA0, 8'h50, 5);
    expect_pkt("midurgent_dllp", start + 5, 8'hD0, 8'h51, 1);

    // ---- link drops mid TLP ----
    start = mon_cnt;
    fork
      drive_tlp(1, 4, 8'h60);
      begin
        for (int t = 0; t < 200 && mon_cnt < start + 1; t++) @(negedge clk);
        link_up = 1'b0;
      end
    join
    exp_tlp++;
    check("linkdown_pkt_complete", 64'(mon_cnt - start), 64'd4);
    expect_pkt("linkdown_tlp", start, 8'hA0, 8'h60, 4);
    fork
      drive_tlp(1, 1, 8'h61);
      begin
        nonidle = 0;
        for (int t = 0; t < 6; t++) begin
          @(negedge clk);
          if (grant != 2'b00) nonidle++;
        end
        check("linkdown_grant_held_idle", 64'(nonidle), 64'd0);
        check("linkdown_no_beats", 64'(mon_cnt - start), 64'd4);
        link_up = 1'b1;
      end
    join
    exp_tlp++;
    expect_pkt("linkup_tlp", start + 4, 8'hA0, 8'h61, 1);
    check("linkdown_tlp_count", 64'(tlp_count), 64'(exp_tlp));

    // ---- reset pulsed mid DLLP ----
    rdy_mode = 2; rdy = 1'b0;
    start = mon_cnt;
    @(negedge clk);
    dllp_tvalid = 1'b1; dllp_tdata = tdat(8'hD0, 8'h70, 0);
    dllp_tkeep = 4'h3; dllp_tuser = 3'b010; dllp_tlast = 1'b0;
    @(negedge clk);
    check("rst_pre_grant", 64'(grant), 64'b10);
    rdy = 1'b1;
    @(negedge clk);
    dllp_tdata = tdat(8'hD0, 8'h70, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({grant, phy_tvalid, tlp_tready, dllp_tready}), 64'd0);
    check("rst_mid_counts", 64'({tlp_count, dllp_count}), 64'd0);
    check("rst_mid_starve", 64'(dut.starve_cnt), 64'd0);
    dllp_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_idle", 64'({grant, phy_tvalid}), 64'd0);
    check("rst_abandoned_beats", 64'(mon_cnt - start), 64'd1);

    // ---- tlp counter wrap ----
    rdy_mode = 0;
    force dut.tlp_count_o = 16'hFFFF;
    @(negedge clk);
    release dut.tlp_count_o;
    #1;
    check("wrap_preload", 64'(tlp_count), 64'hFFFF);
    drive_tlp(1, 1, 8'h80);
    check("wrap_to_zero", 64'(tlp_count), 64'h0000);
    check("wrap_dllp_untouched", 64'(dllp_count), 64'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
